bcd_scan_ctrl: RTL and testbench
================================

# bcd_scan_ctrl

Time-multiplexed scan controller that shares one `bcd_to_dec_decoder` between NUM_DIGITS BCD digit positions. It accepts a packed multi-digit word over a valid/ready load port into a one-deep pending buffer. It swaps that word into the active register only at a frame boundary, then steps through the digits with a programmable dwell and a one-cycle blanking gap. Per digit, it drives the decoder inputs and a one-hot digit select. It sits between the counter/datapath logic that produces BCD values and the decimal indicator driver.

## Interface
Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (2..8)
- DWELL, 1000, cycles each digit is displayed (>=1)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  scan enable; low forces IDLE
- load_valid  in  1  load request
- load_ready  out  1  pending buffer empty, load will be accepted
- load_data  in  4*NUM_DIGITS  packed BCD, digit 0 in [3:0]
- bcd_out  out  4  current digit value to decoder a3..a0 (bcd_out[0]=a0)
- dec_out  out  10  decoder o9..o0 one-hot (dec_out[0]=o0), all zero when blank/invalid
- dig_sel  out  NUM_DIGITS  one-hot digit enable, zero when blank
- frame_done  out  1  one-cycle pulse after last digit's dwell
- err  out  1  sticky: an active digit >9 was scanned

## Operation
- States: IDLE, SCAN, BLANK.
- IDLE: dig_sel=0, bcd_out=0, digit index=0, dwell counter=0. If pending full, swap pending->active and clear pending. If enable=1, go to SCAN next cycle (digit 0).
- SCAN: dig_sel=one-hot(index), bcd_out=active[index]. The counter counts 0..DWELL-1; at DWELL-1 go to BLANK.
- BLANK: exactly one cycle with dig_sel=0, dec_out=0. Then the index increments and the FSM goes to SCAN.
- On the last index, index wraps to 0 and frame_done pulses in the BLANK cycle. If pending full, the swap happens in that same BLANK cycle. The new word is used from the next SCAN.
- Load: accepted when load_valid & load_ready; data goes to pending, and pending is full from the next cycle. load_ready = ~pending_full.
- No overwrite of pending and no drop; the producer stalls.
- Invalid digit (value 10..15) in SCAN: dec_out=0, dig_sel still asserted, bcd_out shows the raw value. err sets the next cycle and stays set until rst.
- enable low in any state: IDLE next cycle. The current digit is abandoned, and no frame_done is issued for the partial frame.
- rst mid-operation: all state is cleared in the same edge; pending and active are zeroed.

## Timing
- Reset values:
  - state: IDLE
  - load_ready: 1
  - bcd_out, dec_out, dig_sel: 0
  - frame_done, err: 0
  - active word, pending word: 0
- All outputs are registered except dec_out, which is a combinational decode of registered bcd_out, gated by registered blank/valid.
- Frame period = NUM_DIGITS*(DWELL+1) cycles.
- Load-to-display latency:
  - in IDLE: accept at T; swap at T+1; with enable high, SCAN digit 0 at T+2.
  - while scanning: the new word is displayed from the first SCAN after the next frame boundary.
- The counter width is clog2(DWELL) with a minimum of 1. When DWELL=1, SCAN lasts one cycle.
- A load at T accepted while pending is empty, followed by a frame boundary at T+1, swaps at T+1. load_ready returns high at T+2.

## Structure
- Shared package `bcd_pkg`: state enum (IDLE/SCAN/BLANK), BCD_W=4, DEC_W=10, BCD_MAX=9.
- One sub-module: instantiate the existing `bcd_to_dec_decoder` (ports a0..a3, o0..o9) for dec_out, with its outputs ANDed with the digit-valid/not-blank qualifier.
- Pending buffer, dwell counter, index counter and FSM stay in `bcd_scan_ctrl`.

## Test plan
- Reset check: after rst, all outputs 0, load_ready=1. Then load 0x4321 with NUM_DIGITS=4, DWELL=3, enable=1:
  - dig_sel sequence 0001,0000,0010,0000,...; each nonzero phase lasts 3 cycles.
  - bcd_out 1,2,3,4; dec_out 0x002,0x004,0x008,0x010.
  - frame_done pulses every 16 cycles.
- Back-to-back load during SCAN with 0x9876:
  - load_ready=0 until the frame boundary.
  - A second load_valid held high stalls and is not lost.
  - The next frame shows 6,7,8,9.
- Invalid digit: load 0x00A0. At digit 1, dig_sel=0010, bcd_out=0xA and dec_out=0. err=1 from the next cycle and persists through later frames.
- enable dropped mid-digit 2: IDLE on the next cycle, dig_sel=0, no frame_done. Re-enable restarts at digit 0 with a full dwell.
- rst asserted mid-SCAN with pending full: next cycle all outputs are at reset values, load_ready=1, err=0, and the active word reads back 0 on re-enable.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the multiplexed BCD scan controller and its
// BCD-to-decimal decoder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam int BCD_W   = 4;
    localparam int DEC_W   = 10;
    localparam int BCD_MAX = 9;

    function automatic logic bcd_is_valid(input logic [BCD_W-1:0] v);
        return (v <= BCD_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_to_dec_decoder.sv
// BCD-to-decimal one-of-ten decoder; inputs 10..15 leave every output low.
module bcd_to_dec_decoder
    import bcd_pkg::*;
(
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    output logic o0,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic o4,
    output logic o5,
    output logic o6,
    output logic o7,
    output logic o8,
    output logic o9
);

    logic [BCD_W-1:0] code_s;
    logic [DEC_W-1:0] dec_s;

    assign code_s = {a3, a2, a1, a0};

    always_comb begin
        dec_s = '0;
        if (bcd_is_valid(code_s)) begin
            dec_s = DEC_W'(1) << code_s;
        end else begin
            dec_s = '0;
        end
    end

    assign {o9, o8, o7, o6, o5, o4, o3, o2, o1, o0} = dec_s;

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller: one-deep load buffer, frame-boundary word
// swap, per-digit dwell with a one-cycle blanking gap, and a shared decoder.
module bcd_scan_ctrl
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
    output logic [BCD_W-1:0]            bcd_out,
    output logic [DEC_W-1:0]            dec_out,
    output logic [NUM_DIGITS-1:0]       dig_sel,
    output logic                        frame_done,
    output logic                        err
);

    localparam int WORD_W = BCD_W * NUM_DIGITS;
    localparam int CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_W-1:0]      active_q, active_d;
    logic [WORD_W-1:0]      pending_q, pending_d;
    logic                   load_ready_q, load_ready_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]  dig_sel_q, dig_sel_d;
    logic                   show_q, show_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_q, err_d;
    logic                   swap_s;
    logic [BCD_W-1:0]       digit_s;
    logic [DEC_W-1:0]       dec_raw_s;

    // A full pending buffer moves to active while idle or in the last blank of a frame.
    assign swap_s = !load_ready_q &&
                    ((state_q == IDLE) || ((state_q == BLANK) && (idx_q == IDX_LAST)));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        pending_d    = pending_q;
        load_ready_d = load_ready_q;

        if (swap_s) begin
            active_d     = pending_q;
            pending_d    = '0;
            load_ready_d = 1'b1;
        end else if (load_valid && load_ready_q) begin
            pending_d    = load_data;
            load_ready_d = 1'b0;
        end else begin
            pending_d    = pending_q;
        end

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SCAN;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                SCAN: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end else begin
                        state_d = SCAN;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output registers are computed from the next state so they line up with state_q.
    always_comb begin
        digit_s      = BCD_W'(active_d >> (int'(idx_d) * BCD_W));
        bcd_d        = '0;
        dig_sel_d    = '0;
        show_d       = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q || ((state_q == SCAN) && !bcd_is_valid(bcd_q));
        if (state_d == SCAN) begin
            bcd_d     = digit_s;
            dig_sel_d = NUM_DIGITS'(1) << idx_d;
            show_d    = bcd_is_valid(digit_s);
        end else if (state_d == BLANK) begin
            frame_done_d = (idx_d == IDX_LAST);
        end else begin
            bcd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            load_ready_q <= 1'b1;
            bcd_q        <= '0;
            dig_sel_q    <= '0;
            show_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            bcd_q        <= bcd_d;
            dig_sel_q    <= dig_sel_d;
            show_q       <= show_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    bcd_to_dec_decoder u_dec (
        .a0 (bcd_q[0]),
        .a1 (bcd_q[1]),
        .a2 (bcd_q[2]),
        .a3 (bcd_q[3]),
        .o0 (dec_raw_s[0]),
        .o1 (dec_raw_s[1]),
        .o2 (dec_raw_s[2]),
        .o3 (dec_raw_s[3]),
        .o4 (dec_raw_s[4]),
        .o5 (dec_raw_s[5]),
        .o6 (dec_raw_s[6]),
        .o7 (dec_raw_s[7]),
        .o8 (dec_raw_s[8]),
        .o9 (dec_raw_s[9])
    );

    assign dec_out    = dec_raw_s & {DEC_W{show_q}};
    assign bcd_out    = bcd_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl: a frame-position reference model queues
// the expected outputs of every cycle and a monitor compares them.
module tb_bcd_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 3;
    localparam int F  = ND * (DW + 1);

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] bcd;
        logic [9:0] dec;
        logic       fd;
        logic       err;
        logic       ready;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  bcd_out;
    logic [9:0]  dec_out;
    logic [3:0]  dig_sel;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int failures = 0;

    exp_t        exp_q[$];
    logic [15:0] prod_q[$];
    bit          mon_en = 1'b0;
    bit          lv_r = 1'b0;
    logic [15:0] ld_r = 16'h0000;

    // reference model state: running flag, position inside the frame, buffers
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_act = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    bit          m_pfull = 1'b0;
    bit          m_err = 1'b0;

    bcd_scan_ctrl #(.NUM_DIGITS(ND), .DWELL(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bcd_out    (bcd_out),
        .dec_out    (dec_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nib(input logic [15:0] w, input int d);
        return 4'((w >> (4 * d)) & 16'h000F);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit lv,
                              input logic [15:0] ld, output bit acc);
        exp_t e;
        bit   swap;
        int   d;
        acc = 1'b0;
        if (r) begin
            m_run = 1'b0; m_pos = 0; m_act = 16'h0000; m_pend = 16'h0000;
            m_pfull = 1'b0; m_err = 1'b0;
        end else begin
            d = m_pos / (DW + 1);
            if (m_run && (m_pos % (DW + 1) != DW) && (nib(m_act, d) > 4'd9)) m_err = 1'b1;
            swap = m_pfull && (!m_run || (m_pos == F - 1));
            acc  = lv && !m_pfull;
            if (swap) begin
                m_act = m_pend;
                m_pfull = 1'b0;
            end else if (acc) begin
                m_pend = ld;
                m_pfull = 1'b1;
            end
            if (!en) begin
                m_run = 1'b0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % F;
            end
        end
        e = '0;
        e.ready = !m_pfull;
        e.err = m_err;
        if (m_run) begin
            d = m_pos / (DW + 1);
            if (m_pos % (DW + 1) == DW) begin
                e.fd = (d == ND - 1);
            end else begin
                e.sel = 4'(1 << d);
                e.bcd = nib(m_act, d);
                e.dec = (e.bcd <= 4'd9) ? (10'd1 << e.bcd) : 10'd0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit en);
        bit acc;
        @(negedge clk);
        if (!lv_r && prod_q.size() > 0) begin
            lv_r = 1'b1;
            ld_r = prod_q.pop_front();
        end
        rst = r;
        enable = en;
        load_valid = lv_r;
        load_data = ld_r;
        model_step(r, en, lv_r, ld_r, acc);
        if (acc) lv_r = 1'b0;
        mon_en = 1'b1;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        if ($urandom_range(0, 3) == 0) begin
            w = 16'($urandom);
        end else begin
            for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    // monitor: compares every cycle's outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("dig_sel", dig_sel, e.sel);
                    chk("bcd_out", bcd_out, e.bcd);
                    chk("dec_out", dec_out, e.dec);
                    chk("frame_done", frame_done, e.fd);
                    chk("err", err, e.err);
                    chk("load_ready", load_ready, e.ready);
                end
            end
        end
    end

    initial begin
        int guard;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // first word loaded while idle, then scanning starts
        prod_q.push_back(16'h4321);
        step(1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b1);

        // back-to-back loads during scanning; the second one must stall
        prod_q.push_back(16'h9876);
        prod_q.push_back(16'h1357);
        repeat (60) step(1'b0, 1'b1);

        // invalid digit in position 1
        prod_q.push_back(16'h00A0);
        repeat (40) step(1'b0, 1'b1);

        // drop enable in the middle of digit 2
        guard = 0;
        while (!(m_run && (m_pos / (DW + 1) == 2) && (m_pos % (DW + 1) == 1)) && guard < 200) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("wait_digit2", 32'(guard < 200), 32'd1);
        step(1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b1);

        // reset while scanning with the pending buffer full
        prod_q.push_back(16'h5555);
        guard = 0;
        while (!(m_pfull && m_run && (m_pos % (DW + 1) != DW)) && guard < 100) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("wait_pending_full", 32'(guard < 100), 32'd1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (prod_q.size() == 0 && $urandom_range(0, 19) == 0) prod_q.push_back(rand_word());
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 49) != 0));
        end

        @(posedge clk);
        #4;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
